// File: rtl/regfile_mp.sv
// Multi-read-port register file with r0 hard-wired to zero and a sweep-based full clear.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     clr_req,
    output logic                     busy
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_fire;

    // Control: reset starts a sweep from index 0, regardless of current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == CLEAR);

    // A clear request in the same cycle pre-empts the write.
    assign wr_fire = wr_en && !busy && !clr_req && !rst && (wr_addr != '0);

    always_ff @(posedge clk) begin
        if (busy) begin
            mem_q[cnt_q[ADDR_W-1:0]] <= '0;
        end else if (wr_fire) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rdv;

        assign ra = rd_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            rdv = '0;
            if (!busy && (ra != '0)) begin
`ifdef REGFILE_BYPASS_EN
                if (wr_en && (wr_addr == ra)) begin
                    rdv = wr_data;
                end else begin
                    rdv = mem_q[ra];
                end
`else
                rdv = mem_q[ra];
`endif
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = rdv;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboarded random + directed bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic                     clk;
    logic                     rst;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     clr_req;
    logic                     busy;

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
        .clk     (clk),
        .rst     (rst),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .clr_req (clr_req),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic                     busy;
        logic [NUM_RD*DATA_W-1:0] rd;
        logic [NUM_RD*ADDR_W-1:0] ra;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: array contents plus remaining clear cycles.
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_left;   // cycles of clearing still to perform; 0 means idle
    int                m_pos;    // next index the sweep will zero

    function automatic logic [DATA_W-1:0] model_read(int a, logic we, int wa, logic [DATA_W-1:0] wd);
        if (m_left > 0 || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && wa == a) return wd;
`endif
        return m_mem[a];
    endfunction

    task automatic model_edge(logic r, logic we, int wa, logic [DATA_W-1:0] wd, logic clr);
        if (m_left > 0) begin
            m_mem[m_pos] = '0;
            m_pos++;
            m_left--;
        end else if (clr) begin
            m_left = DEPTH;
            m_pos  = 0;
        end else if (we && wa != 0 && !r) begin
            m_mem[wa] = wd;
        end
        if (r) begin
            m_left = DEPTH;
            m_pos  = 0;
        end
    endtask

    task automatic cycle(logic r, logic we, int wa, logic [DATA_W-1:0] wd, logic clr, int ra0, int ra1);
        exp_t e;
        @(posedge clk);
        #1;
        rst     = r;
        wr_en   = we;
        wr_addr = ADDR_W'(wa);
        wr_data = wd;
        clr_req = clr;
        rd_addr = {ADDR_W'(ra1), ADDR_W'(ra0)};
        e.busy = (m_left > 0);
        e.rd   = {model_read(ra1, we, wa, wd), model_read(ra0, we, wa, wd)};
        e.ra   = rd_addr;
        exp_q.push_back(e);
        model_edge(r, we, wa, wd, clr);
    endtask

    task automatic idle(int ra0, int ra1);
        cycle(1'b0, 1'b0, 0, '0, 1'b0, ra0, ra1);
    endtask

    task automatic check_busy_len(string name, int limit);
        int n = 0;
        for (int k = 0; k < limit; k++) begin
            idle(k % DEPTH, 0);
            @(negedge clk);
            if (busy) n++;
        end
        n_tests++;
        if (n != DEPTH) begin
            n_fail++;
            $display("FAIL %s: busy cycles got %0d expected %0d", name, n, DEPTH);
        end
    endtask

    // Monitor: outputs are combinational, so one expected entry per driven cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            if (busy !== e.busy || rd_data !== e.rd) begin
                n_fail++;
                $display("FAIL rd/busy @%0t ra=%h: got busy=%b rd=%h expected busy=%b rd=%h",
                         $time, e.ra, busy, rd_data, e.busy, e.rd);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_left  = DEPTH;
        m_pos   = 0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        clr_req = 1'b0;
        rd_addr = '0;

        // Power-up reset: one cycle, then busy must last exactly DEPTH cycles.
        check_busy_len("reset_sweep", DEPTH + 8);
        for (int a = 1; a < DEPTH; a += 2) idle(a, (a + 1) % DEPTH);

        // Basic write/read and r0 protection.
        cycle(1'b0, 1'b1, 1, 32'd5, 1'b0, 0, 0);
        idle(1, 0);
        cycle(1'b0, 1'b1, 0, 32'hDEADBEEF, 1'b0, 0, 1);
        idle(0, 0);

        // Same-cycle write/read of r8.
        cycle(1'b0, 1'b1, 8, 32'h12, 1'b0, 8, 1);
        idle(8, 8);

        // Clear with a re-request at index 10 and a dropped write at index 2.
        cycle(1'b0, 1'b1, 3, 32'd7, 1'b0, 0, 0);
        idle(3, 8);
        cycle(1'b0, 1'b0, 0, '0, 1'b1, 3, 0);
        for (int k = 0; k < DEPTH + 4; k++) begin
            cycle(1'b0, (k == 2), 3, 32'h55, (k == 10), 3, 1);
            @(negedge clk);
        end
        idle(3, 1);

        // clr_req and wr_en together in IDLE: write lost.
        cycle(1'b0, 1'b1, 4, 32'hAA, 1'b0, 0, 0);
        cycle(1'b0, 1'b1, 5, 32'hBB, 1'b1, 4, 5);
        for (int k = 0; k < DEPTH + 2; k++) idle(5, 4);

        // Reset mid-sweep at index 20.
        cycle(1'b0, 1'b0, 0, '0, 1'b1, 0, 0);
        for (int k = 0; k < 20; k++) idle(k, 0);
        cycle(1'b1, 1'b0, 0, '0, 1'b0, 0, 0);
        check_busy_len("mid_sweep_reset", DEPTH + 8);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            logic r, we, clr;
            int   wa, ra0, ra1;
            r   = ($urandom_range(0, 299) == 0);
            clr = ($urandom_range(0, 79) == 0);
            we  = ($urandom_range(0, 1) == 1);
            wa  = $urandom_range(0, DEPTH - 1);
            ra0 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, DEPTH - 1);
            ra1 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, DEPTH - 1);
            cycle(r, we, wa, $urandom, clr, ra0, ra1);
        end
        idle(0, 0);
        @(negedge clk);
        @(negedge clk);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
